// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port of the boot-time program loader.
// The master side is the stream source; the slave side is the loader.
interface program_loader_if;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        busy;
    logic        cpu_run;
    logic        error;
    logic [15:0] words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_din, busy, cpu_run, error, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_din, busy, cpu_run, error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles big-endian words from a counted byte stream, writes
// them into instruction memory, then releases the CPU via cpu_run.
//
// state  | meaning
// IDLE   | waiting for start
// CNT_HI | receiving word count high byte
// CNT_LO | receiving word count low byte, header accept/reject
// DATA   | shifting stream bytes into the assembly register
// WRITE  | one-cycle memory write of the assembled word
// DONE   | image complete, cpu_run held until reset
// ERR    | header rejected, error held until reset
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    program_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [23:0] asm_q, asm_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] idx_q, idx_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;

    logic        in_ready;
    logic        xfer;
    logic [15:0] n_full;
    logic [15:0] idx_inc;

    assign in_ready = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) || (state_q == S_DATA);
    assign xfer     = bus.in_valid && in_ready;
    assign n_full   = {n_q[15:8], bus.in_data};
    assign idx_inc  = idx_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            idx_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (xfer) begin
                    n_d     = {bus.in_data, n_q[7:0]};
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, n_full} > MAX_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_DATA;
                        byte_cnt_d = '0;
                        idx_d      = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d      = {asm_q[15:0], bus.in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte: the memory port is loaded here so it is
                    // registered and valid for exactly the WRITE cycle.
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = S_WRITE;
                        mem_we_d   = 1'b1;
                        mem_addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        mem_din_d  = {asm_q, bus.in_data};
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == n_q) ? S_DONE : S_DATA;
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready     = in_ready;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_din      = mem_din_q;
    assign bus.busy         = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                              (state_q == S_DATA)   || (state_q == S_WRITE);
    assign bus.cpu_run      = (state_q == S_DONE);
    assign bus.error        = (state_q == S_ERR);
    assign bus.words_loaded = idx_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: stimulus queues expected memory
// writes, a negedge monitor checks every mem_we pulse against them.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 1024;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    logic        prev_we = 1'b0;
    wr_t         exp_q[$];
    logic [31:0] img[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_loader_if bus();

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Write monitor: every mem_we pulse must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                check("we_single_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_addr, e.addr);
                    check("wr_data", bus.mem_din, e.data);
                end
            end
            prev_we = bus.mem_we;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_we"},  {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_addr"},    bus.mem_addr, 32'd0);
        check({tag, "_din"},     bus.mem_din, 32'd0);
        check({tag, "_busy"},    {31'd0, bus.busy}, 32'd0);
        check({tag, "_cpu_run"}, {31'd0, bus.cpu_run}, 32'd0);
        check({tag, "_error"},   {31'd0, bus.error}, 32'd0);
        check({tag, "_ready"},   {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_words"},   {16'd0, bus.words_loaded}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int k;
        if (gaps) begin
            k = $urandom_range(0, 3);
            repeat (k) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) flag("byte_accept_timeout");
    endtask

    task automatic start_load(output int unsigned c0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c0 = cyc;
    endtask

    // Reference: N words land at BASE + 4*i in order; continuous stream
    // completes in 2 + 5*N cycles; words_loaded ends at N.
    task automatic run_load(input logic [15:0] n, input bit gaps, input bit chk_lat);
        int unsigned c0;
        bit          seen;
        logic [31:0] w;
        wr_t         e;
        start_load(c0);
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        if (n == 16'd0) begin
            check("empty_cpu_run", {31'd0, bus.cpu_run}, 32'd1);
            check("empty_error",   {31'd0, bus.error}, 32'd0);
            check("empty_words",   {16'd0, bus.words_loaded}, 32'd0);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            w = img[i];
            send_byte(w[31:24], gaps);
            send_byte(w[23:16], gaps);
            send_byte(w[15:8], gaps);
            send_byte(w[7:0], gaps);
            e.addr = BASE + 32'(4 * i);
            e.data = w;
            exp_q.push_back(e);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.cpu_run;
        end
        if (!seen) flag("cpu_run_timeout");
        else if (chk_lat) check("latency", 32'(cyc - c0), 32'(2 + 5 * int'(n)));
        check("done_words", {16'd0, bus.words_loaded}, {16'd0, n});
        check("done_error", {31'd0, bus.error}, 32'd0);
        check("done_busy",  {31'd0, bus.busy}, 32'd0);
        start_load(c0);
        check("done_ignores_start", {30'd0, bus.cpu_run, bus.in_ready}, 32'd2);
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin
        int unsigned c0;
        int          n;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("por");
        rst_n = 1'b1;

        img.delete();
        img.push_back(32'h2008_0005);
        img.push_back(32'hAC09_0004);
        run_load(16'd2, 1'b0, 1'b1);
        do_reset();

        run_load(16'd0, 1'b0, 1'b0);
        do_reset();

        start_load(c0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        check("over_error",   {31'd0, bus.error}, 32'd1);
        check("over_ready",   {31'd0, bus.in_ready}, 32'd0);
        check("over_cpu_run", {31'd0, bus.cpu_run}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("over_no_consume", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        start_load(c0);
        check("over_sticky", {30'd0, bus.error, bus.busy}, 32'd2);
        do_reset();

        fill_img(MAXW);
        run_load(16'(MAXW), 1'b0, 1'b1);
        do_reset();

        repeat (6) begin
            n = $urandom_range(1, 8);
            fill_img(n);
            run_load(16'(n), 1'b1, 1'b0);
            do_reset();
        end

        start_load(c0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        do_reset();
        img.delete();
        img.push_back(32'h1234_5678);
        run_load(16'd1, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("writes_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
